// File: rtl/fft_host_link.sv
// rtl/fft_host_link.sv - host-side sample streamer and result collector for the DFT core bus
//
// Purpose:
//   Holds a local sample buffer loaded over a simple write port and streams a
//   programmed number of samples to the core on the AR channel. It then collects
//   the same number of 32-bit results from the AW channel into a local result
//   buffer. A watchdog aborts the collection phase if the core goes quiet.
//
// Ports:
//   clk, Reset        single rising-edge clock, synchronous active-high reset
//   start             one-cycle transaction request (honoured in IDLE only)
//   samp_number       transaction length, captured on start
//   ld_we/addr/data   sample buffer write port (dropped while busy)
//   rd_addr/rd_data   result buffer read port, registered, one cycle latency
//   ARDATA/ARVALID    sample word and valid towards the core
//   ARREADY, ARBURST  core accept and burst index for the sample channel
//   AWDATA/AWVALID    result word {real, imag} and valid from the core
//   AWREADY           host accept for the result channel
//   AWBURST           core burst index for the result channel
//   last_ar/awburst   burst index seen on the most recent accepted beat
//   busy, done, err   status; done is a one-cycle pulse, err is sticky until start
//   res_count         number of results captured in the current transaction

module fft_host_link #(
    parameter int N       = 4,
    parameter int AW      = 12,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [AW-1:0] samp_number,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic [31:0]   ARDATA,
    output logic          ARVALID,
    input  logic          ARREADY,
    input  logic [N:0]    ARBURST,
    input  logic [31:0]   AWDATA,
    input  logic          AWVALID,
    output logic          AWREADY,
    input  logic [N:0]    AWBURST,
    output logic [N:0]    last_arburst,
    output logic [N:0]    last_awburst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] res_count
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT_RES,
        S_RECV,
        S_FIN
    } state_t;

    logic [31:0] samp_mem [0:DEPTH-1];
    logic [31:0] res_mem  [0:DEPTH-1];

    state_t        state_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] res_count_q;
    logic [CW-1:0] wd_q;
    logic [31:0]   ardata_q;
    logic          arvalid_q;
    logic          awready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [N:0]    last_arburst_q;
    logic [N:0]    last_awburst_q;
    logic [31:0]   rd_data_q;

    logic [AW-1:0] idx_d;
    logic [AW-1:0] res_count_d;
    logic [CW-1:0] wd_d;
    logic          ar_hs;
    logic          aw_hs;
    logic          wd_expired;

    assign ar_hs       = arvalid_q & ARREADY;
    assign aw_hs       = AWVALID & awready_q;
    assign idx_d       = idx_q + AW'(1);
    assign res_count_d = res_count_q + AW'(1);
    assign wd_d        = wd_q + CW'(1);
    // The counter is cleared on the accepting edge, and the abort still has to
    // pass through FIN before done is seen; expiring at TIMEOUT-3 places the
    // done pulse exactly TIMEOUT cycles after the last accepted result.
    assign wd_expired  = (wd_q == CW'(TIMEOUT - 3));

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            idx_q          <= '0;
            res_count_q    <= '0;
            wd_q           <= '0;
            ardata_q       <= '0;
            arvalid_q      <= 1'b0;
            awready_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            last_arburst_q <= '0;
            last_awburst_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (ar_hs) begin
                last_arburst_q <= ARBURST;
            end
            if (aw_hs) begin
                last_awburst_q <= AWBURST;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q       <= samp_number;
                        idx_q       <= '0;
                        res_count_q <= '0;
                        busy_q      <= 1'b1;
                        if (samp_number == '0) begin
                            err_q   <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    ardata_q  <= samp_mem[idx_q];
                    arvalid_q <= 1'b1;
                    state_q   <= S_SEND;
                end

                S_SEND: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        idx_q     <= idx_d;
                        wd_q      <= '0;
                        if (idx_d == len_q) begin
                            awready_q <= 1'b1;
                            state_q   <= S_WAIT_RES;
                        end else begin
                            state_q   <= S_FETCH;
                        end
                    end
                end

                // WAIT_RES and RECV differ only in whether a result has been
                // seen yet; a single-result transaction finishes straight from WAIT_RES.
                S_WAIT_RES, S_RECV: begin
                    if (aw_hs) begin
                        res_count_q <= res_count_d;
                        wd_q        <= '0;
                        if (res_count_d == len_q) begin
                            awready_q <= 1'b0;
                            state_q   <= S_FIN;
                        end else begin
                            state_q   <= S_RECV;
                        end
                    end else if (wd_expired) begin
                        err_q     <= 1'b1;
                        awready_q <= 1'b0;
                        state_q   <= S_FIN;
                    end else begin
                        wd_q <= wd_d;
                    end
                end

                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Buffers carry no reset; their contents are undefined until written.
    always_ff @(posedge clk) begin
        if (ld_we && !busy_q) begin
            samp_mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            res_mem[res_count_q] <= AWDATA;
        end
    end

    // Read-before-write: a same-address write on this edge returns the old word.
    always_ff @(posedge clk) begin
        if (Reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= res_mem[rd_addr];
        end
    end

    assign rd_data      = rd_data_q;
    assign ARDATA       = ardata_q;
    assign ARVALID      = arvalid_q;
    assign AWREADY      = awready_q;
    assign last_arburst = last_arburst_q;
    assign last_awburst = last_awburst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign res_count    = res_count_q;

endmodule

// File: tb/tb_fft_host_link.sv
// tb/tb_fft_host_link.sv - self-checking bench for fft_host_link

module tb_fft_host_link;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [AW-1:0] samp_number;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [31:0]   ARDATA;
    logic          ARVALID;
    logic          ARREADY;
    logic [N:0]    ARBURST;
    logic [31:0]   AWDATA;
    logic          AWVALID;
    logic          AWREADY;
    logic [N:0]    AWBURST;
    logic [N:0]    last_arburst;
    logic [N:0]    last_awburst;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] res_count;

    fft_host_link #(.N(N), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .Reset(Reset), .start(start), .samp_number(samp_number),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .ARDATA(ARDATA), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARBURST(ARBURST),
        .AWDATA(AWDATA), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWBURST(AWBURST),
        .last_arburst(last_arburst), .last_awburst(last_awburst),
        .busy(busy), .done(done), .err(err), .res_count(res_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Handshake between stimulus and model: stimulus bumps these after the edge.
    int n_starts = 0;
    int n_resets = 0;
    int cur_len = 0;
    bit mon_en = 1'b0;
    logic [31:0] smp [16];

    // Model state, written only by the monitor.
    int seen_starts = 0;
    int seen_resets = 0;
    bit active = 1'b0;
    int m_len = 0;
    int ar_sent = 0;
    int aw_got = 0;
    logic [N:0] m_last_ar = '0;
    logic [N:0] m_last_aw = '0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] m_res [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (n_resets != seen_resets) begin
                seen_resets = n_resets;
                active = 1'b0;
                m_len = 0;
                ar_sent = 0;
                aw_got = 0;
                m_last_ar = '0;
                m_last_aw = '0;
                prev_stall = 1'b0;
            end
            if (n_starts != seen_starts) begin
                seen_starts = n_starts;
                active = 1'b1;
                m_len = cur_len;
                ar_sent = 0;
                aw_got = 0;
            end

            chk("busy", busy, active && !done);
            chk("res_count", res_count, aw_got);
            chk("last_arburst", last_arburst, m_last_ar);
            chk("last_awburst", last_awburst, m_last_aw);
            if (prev_stall) begin
                chk("arvalid_hold", ARVALID, 1);
                chk("ardata_hold", ARDATA, prev_data);
            end
            if (ARVALID) chk("arvalid_allowed", active && ar_sent < m_len, 1);
            if (AWREADY) chk("awready_allowed", active && ar_sent == m_len && aw_got < m_len, 1);

            if (ARVALID && ARREADY) begin
                chk("ardata", ARDATA, smp[ar_sent % 16]);
                ar_sent++;
                m_last_ar = ARBURST;
            end
            if (AWVALID && AWREADY) begin
                m_res[aw_got % 16] = AWDATA;
                aw_got++;
                m_last_aw = AWBURST;
            end
            prev_stall = ARVALID && !ARREADY;
            prev_data = ARDATA;

            if (done) begin
                chk("done_expected", active, 1);
                chk("err_at_done", err, (m_len == 0) || (aw_got < m_len));
                active = 1'b0;
            end
        end
    end

    task automatic load(input int a, input logic [31:0] d);
        ld_we = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        tick();
        ld_we = 1'b0;
        smp[a] = d;
    endtask

    task automatic run_txn(input int len, input int stall_at, input int n_ret,
                           input bit burst, input logic [31:0] salt, output int tail);
        int k;
        int stall;
        int guard;
        bit hs;
        logic [31:0] old0;
        old0 = m_res[0];
        tail = 0;
        samp_number = AW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        cur_len = len;
        n_starts++;
        if (len == 0) begin
            chk("zero_busy_t1", busy, 1);
            chk("zero_done_t1", done, 0);
            chk("zero_arvalid_t1", ARVALID, 0);
            tick();
            chk("zero_done_t2", done, 1);
            chk("zero_err_t2", err, 1);
            chk("zero_arvalid_t2", ARVALID, 0);
            tick();
            return;
        end
        chk("fetch_no_valid", ARVALID, 0);
        k = 0;
        stall = 0;
        guard = 0;
        while (k < len && guard < 200) begin
            if (guard == 1) begin
                chk("arvalid_t2", ARVALID, 1);
                chk("ardata_first", ARDATA, smp[0]);
            end
            ARBURST = (burst && k == 2) ? 5'd5 : k[N:0];
            if (ARVALID && k == stall_at && stall < 5) begin
                ARREADY = 1'b0;
                stall++;
            end else begin
                ARREADY = 1'b1;
            end
            hs = ARVALID && ARREADY;
            if (hs && stall_at < 0) chk("ar_cadence", guard, 2 * k + 1);
            if (burst && guard == 3) begin
                start = 1'b1;
                samp_number = AW'(1);
                ld_we = 1'b1;
                ld_addr = '0;
                ld_data = 32'hDEAD_BEEF;
            end
            tick();
            start = 1'b0;
            ld_we = 1'b0;
            if (hs) begin
                k++;
                if (burst && k == 3) chk("last_arburst_5", last_arburst, 5);
            end
            guard++;
        end
        chk("samples_sent", k, len);
        if (stall_at >= 0) chk("stall_cycles", stall, 5);

        guard = 0;
        while (!AWREADY && guard < 50) begin
            tick();
            guard++;
        end
        chk("awready_seen", AWREADY, 1);

        for (int b = 0; b < n_ret; b++) begin
            AWVALID = 1'b1;
            AWDATA = ((b + 1) * 32'h1111_0000) ^ salt;
            AWBURST = (burst && b == 0) ? 5'd7 : 5'd1;
            tick();
            if (burst && b == 0) begin
                chk("last_awburst_7", last_awburst, 7);
                chk("rd_old_on_collide", rd_data, old0);
            end
            if (burst && b == 1) chk("rd_new_after_write", rd_data, 32'h1111_0000 ^ salt);
        end
        AWVALID = 1'b0;
        if (n_ret == len) chk("awready_drop", AWREADY, 0);

        tail = 1;
        while (!done && tail < 100) begin
            tick();
            tail++;
        end
        chk("done_seen", done, 1);
        tick();
        chk("done_single", done, 0);
    endtask

    int tail;

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        samp_number = '0;
        ld_we = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        rd_addr = '0;
        ARREADY = 1'b0;
        ARBURST = '0;
        AWDATA = '0;
        AWVALID = 1'b0;
        AWBURST = '0;
        for (int i = 0; i < 16; i++) begin
            smp[i] = '0;
            m_res[i] = '0;
        end
        tick();
        tick();
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_ardata", ARDATA, 0);
        chk("rst_awready", AWREADY, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_last_arburst", last_arburst, 0);
        chk("rst_last_awburst", last_awburst, 0);
        chk("rst_rd_data", rd_data, 0);
        Reset = 1'b0;
        n_resets++;
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) load(i, 32'(i + 1));

        // Basic four-sample transaction, results returned back-to-back.
        ARREADY = 1'b1;
        run_txn(4, -1, 4, 1'b0, 32'h0, tail);
        chk("t1_tail", tail, 2);
        chk("t1_res_count", res_count, 4);
        chk("t1_err", err, 0);
        rd_addr = AW'(2);
        tick();
        chk("t1_rd2_literal", rd_data, 32'h3333_0000);
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i);
            tick();
            chk("t1_rd_model", rd_data, m_res[i]);
        end

        // Stall on sample 2.
        run_txn(4, 1, 4, 1'b0, 32'h0000_0100, tail);
        chk("t2_res_count", res_count, 4);
        chk("t2_err", err, 0);

        // Zero-length request.
        run_txn(0, -1, 0, 1'b0, 32'h0, tail);
        chk("t3_err_sticky", err, 1);

        // Only two of four results: watchdog abort.
        run_txn(4, -1, 2, 1'b0, 32'h0000_0200, tail);
        chk("t4_tail", tail, TO);
        chk("t4_err", err, 1);
        chk("t4_res_count", res_count, 2);

        // Reset while a sample is being offered.
        samp_number = AW'(4);
        ARREADY = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cur_len = 4;
        n_starts++;
        begin
            int g;
            g = 0;
            while (!ARVALID && g < 10) begin
                tick();
                g++;
            end
        end
        chk("t5_reach_send", ARVALID, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_resets++;
        chk("t5_arvalid", ARVALID, 0);
        chk("t5_busy", busy, 0);
        chk("t5_awready", AWREADY, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        chk("t5_last_arburst", last_arburst, 0);
        chk("t5_rd_data", rd_data, 0);
        ARREADY = 1'b1;
        run_txn(4, -1, 4, 1'b0, 32'h0000_0300, tail);
        chk("t5_res_count", res_count, 4);

        // Burst status, colliding read, and start/ld_we while busy.
        rd_addr = '0;
        run_txn(4, -1, 4, 1'b1, 32'h0000_00A5, tail);
        chk("t6_err", err, 0);
        chk("t6_res_count", res_count, 4);

        // Single-sample transaction; sample 0 must still be the loaded word.
        run_txn(1, -1, 1, 1'b0, 32'h0000_0400, tail);
        chk("t7_res_count", res_count, 1);
        chk("t7_err", err, 0);
        chk("t7_smp0_literal", smp[0], 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
